// File: rtl/vdot_result_packer_pkg.sv
// Shared definitions for the FP16 dot-product result path: sizes and the
// packer state encoding, which the dot unit and writeback control reuse.
package vdot_result_packer_pkg;

   localparam int FP16_W    = 16;
   localparam int LANES_DEF = 16;
   localparam int WIDTH_DEF = FP16_W;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FILL  = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

endpackage

// File: rtl/vdot_result_packer_if.sv
// Result-capture and vector-writeback signals of the packer, bundled so the
// dot unit, the packer and the writeback stage share one definition.
interface vdot_result_packer_if
   import vdot_result_packer_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter int WIDTH = WIDTH_DEF
);
   localparam int CW = $clog2(LANES) + 1;

   logic                   clear;
   logic [WIDTH-1:0]       res_in;
   logic                   res_v;
   logic                   res_write;
   logic [LANES*WIDTH-1:0] vec_out;
   logic [LANES-1:0]       vec_ovf;
   logic                   vec_valid;
   logic                   vec_ready;
   logic [CW-1:0]          lane_cnt;
   logic                   overrun;

   // master: result producer plus writeback consumer side
   modport master (
      output clear, res_in, res_v, res_write, vec_ready,
      input  vec_out, vec_ovf, vec_valid, lane_cnt, overrun
   );

   modport slave (
      input  clear, res_in, res_v, res_write, vec_ready,
      output vec_out, vec_ovf, vec_valid, lane_cnt, overrun
   );

endinterface

// File: rtl/vdot_result_packer.sv
// Packs LANES successive scalar dot results into one vector, holds it for a
// valid/ready writeback, and tracks per-lane overflow plus sticky overrun.
module vdot_result_packer
   import vdot_result_packer_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter int WIDTH = WIDTH_DEF
)(
   input  logic                 Clk,
   input  logic                 Rst,
   vdot_result_packer_if.slave  bus
);
   localparam int CW = $clog2(LANES) + 1;

   state_e           r_state;
   state_e           w_state_next;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_next;
   logic             r_overrun;
   logic             w_overrun_next;
   logic [WIDTH-1:0] r_lane [LANES];
   logic             r_ovf  [LANES];
   logic [LANES-1:0] w_we;
   logic             w_full;
   logic             w_hs;
   logic             w_zero;

   assign w_full = (r_state == ST_FULL);
   assign w_hs   = w_full & bus.vec_ready;
   assign w_zero = bus.clear | w_hs;

   // Lane write-enable decode; a write coinciding with the handshake lands in lane 0
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign w_we[gi] = ~bus.clear & bus.res_write &
                           ((~w_full & (r_cnt == CW'(gi))) | (w_hs & (gi == 0)));

         always_ff @(posedge Clk) begin
            if (Rst) begin
               r_lane[gi] <= '0;
               r_ovf[gi]  <= 1'b0;
            end else if (w_we[gi]) begin
               r_lane[gi] <= bus.res_in;
               r_ovf[gi]  <= bus.res_v;
            end else if (w_zero) begin
               r_lane[gi] <= '0;
               r_ovf[gi]  <= 1'b0;
            end
         end

         assign bus.vec_out[gi*WIDTH +: WIDTH] = r_lane[gi];
         assign bus.vec_ovf[gi]                = r_ovf[gi];
      end
   endgenerate

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state   <= ST_EMPTY;
         r_cnt     <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_overrun <= w_overrun_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      w_overrun_next = r_overrun;
      if (bus.clear) begin
         w_state_next = ST_EMPTY;
         w_cnt_next   = '0;
      end else begin
         case (r_state)
            ST_EMPTY, ST_FILL: begin
               if (bus.res_write) begin
                  w_cnt_next   = r_cnt + 1'b1;
                  w_state_next = (r_cnt == CW'(LANES - 1)) ? ST_FULL : ST_FILL;
               end
            end
            ST_FULL: begin
               if (w_hs) begin
                  w_state_next = bus.res_write ? ST_FILL : ST_EMPTY;
                  w_cnt_next   = bus.res_write ? CW'(1) : '0;
               end else if (bus.res_write) begin
                  w_overrun_next = 1'b1;
               end
            end
            default: begin
               w_state_next = ST_EMPTY;
               w_cnt_next   = '0;
            end
         endcase
      end
   end

   assign bus.vec_valid = w_full;
   assign bus.lane_cnt  = r_cnt;
   assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_vdot_result_packer.sv
// Directed bench for vdot_result_packer: a vector table for ordered fill and
// hand-written sequences for backpressure, handshake collisions, flush, reset.
module tb_vdot_result_packer;
   import vdot_result_packer_pkg::*;

   localparam int LANES = 16;
   localparam int WIDTH = 16;

   typedef struct {
      logic [15:0] din;
      logic        dv;
      logic [4:0]  exp_cnt;
      logic        exp_valid;
   } vec_t;

   logic   clk = 1'b0;
   logic   rst;
   int     n_cmp = 0;
   int     n_bad = 0;
   vec_t   tbl [LANES];
   logic [255:0] exp_vec;
   logic [15:0]  exp_ovf;

   vdot_result_packer_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

   vdot_result_packer #(.LANES(LANES), .WIDTH(WIDTH)) dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: act=%h req=%h", nm, act, req);
      end else begin
         $display("ok   %s: %h", nm, act);
      end
   endtask

   task automatic wr(input logic [15:0] d, input logic v);
      bus.res_in    = d;
      bus.res_v     = v;
      bus.res_write = 1'b1;
      tick();
      bus.res_write = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < LANES; i++) begin
         tbl[i].din       = 16'(i + 1);
         tbl[i].dv        = (i == 4);
         tbl[i].exp_cnt   = 5'(i + 1);
         tbl[i].exp_valid = (i == LANES - 1);
      end

      bus.clear = 1'b0; bus.res_in = '0; bus.res_v = 1'b0;
      bus.res_write = 1'b0; bus.vec_ready = 1'b0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;

      // reset state
      chk("rst_vec_out",   bus.vec_out,          '0);
      chk("rst_vec_ovf",   256'(bus.vec_ovf),    '0);
      chk("rst_vec_valid", 256'(bus.vec_valid),  '0);
      chk("rst_lane_cnt",  256'(bus.lane_cnt),   '0);
      chk("rst_overrun",   256'(bus.overrun),    '0);

      // uniform fill of 1.0
      for (int i = 0; i < LANES - 1; i++) wr(16'h3c00, 1'b0);
      chk("fill15_valid", 256'(bus.vec_valid), 256'(0));
      chk("fill15_cnt",   256'(bus.lane_cnt),  256'(15));
      wr(16'h3c00, 1'b0);
      chk("fill16_valid", 256'(bus.vec_valid), 256'(1));
      chk("fill16_vec",   bus.vec_out,         {16{16'h3c00}});
      chk("fill16_ovf",   256'(bus.vec_ovf),   256'(0));
      chk("fill16_cnt",   256'(bus.lane_cnt),  256'(16));
      bus.vec_ready = 1'b1; tick(); bus.vec_ready = 1'b0;
      chk("hs1_valid", 256'(bus.vec_valid), 256'(0));
      chk("hs1_cnt",   256'(bus.lane_cnt),  256'(0));
      chk("hs1_vec",   bus.vec_out,         '0);

      // ordering from the table
      exp_vec = '0;
      exp_ovf = '0;
      for (int i = 0; i < LANES; i++) begin
         wr(tbl[i].din, tbl[i].dv);
         exp_vec[i*16 +: 16] = tbl[i].din;
         exp_ovf[i]          = tbl[i].dv;
         chk($sformatf("ord%0d_cnt", i),   256'(bus.lane_cnt),  256'(tbl[i].exp_cnt));
         chk($sformatf("ord%0d_valid", i), 256'(bus.vec_valid), 256'(tbl[i].exp_valid));
      end
      chk("ord_lane0",  256'(bus.vec_out[15:0]),    256'(16'h0001));
      chk("ord_lane15", 256'(bus.vec_out[255:240]), 256'(16'h0010));
      chk("ord_vec",    bus.vec_out,                exp_vec);
      chk("ord_ovf",    256'(bus.vec_ovf),          256'(16'h0010));

      // backpressure: write while FULL is dropped
      tick();
      chk("bp_hold_valid", 256'(bus.vec_valid), 256'(1));
      wr(16'hbeef, 1'b1);
      chk("bp_overrun", 256'(bus.overrun),   256'(1));
      chk("bp_vec",     bus.vec_out,         exp_vec);
      chk("bp_ovf",     256'(bus.vec_ovf),   256'(16'h0010));
      chk("bp_valid",   256'(bus.vec_valid), 256'(1));
      bus.vec_ready = 1'b1; tick(); bus.vec_ready = 1'b0;
      chk("bp_hs_valid",   256'(bus.vec_valid), 256'(0));
      chk("bp_hs_cnt",     256'(bus.lane_cnt),  256'(0));
      chk("bp_hs_overrun", 256'(bus.overrun),   256'(1));
      tick();
      chk("bp_sticky", 256'(bus.overrun), 256'(1));

      // handshake coinciding with a write; NaN/Inf payloads stored bit-exact
      do_reset();
      chk("rst2_overrun", 256'(bus.overrun), 256'(0));
      for (int i = 0; i < LANES; i++) wr((i % 2 == 0) ? 16'h7e01 : 16'hfc00, 1'b0);
      chk("nan_vec", bus.vec_out, {8{16'hfc00, 16'h7e01}});
      bus.vec_ready = 1'b1;
      wr(16'h4000, 1'b1);
      bus.vec_ready = 1'b0;
      chk("sim_valid",   256'(bus.vec_valid), 256'(0));
      chk("sim_cnt",     256'(bus.lane_cnt),  256'(1));
      chk("sim_vec",     bus.vec_out,         256'(16'h4000));
      chk("sim_ovf",     256'(bus.vec_ovf),   256'(1));
      chk("sim_overrun", 256'(bus.overrun),   256'(0));
      bus.vec_ready = 1'b1; tick(); bus.vec_ready = 1'b0;
      chk("rdy_ign_cnt", 256'(bus.lane_cnt), 256'(1));
      chk("rdy_ign_vec", bus.vec_out,        256'(16'h4000));

      // clear in FULL discards the held vector, keeps overrun
      do_reset();
      for (int i = 0; i < LANES; i++) wr(16'h1234, 1'b1);
      wr(16'h5555, 1'b0);
      chk("cf_overrun", 256'(bus.overrun), 256'(1));
      bus.clear = 1'b1; tick(); bus.clear = 1'b0;
      chk("cf_valid",   256'(bus.vec_valid), 256'(0));
      chk("cf_vec",     bus.vec_out,         '0);
      chk("cf_ovf",     256'(bus.vec_ovf),   256'(0));
      chk("cf_overrun", 256'(bus.overrun),   256'(1));

      // mid-fill clear with a coincident write
      for (int i = 0; i < 7; i++) wr(16'h00a0 + 16'(i), 1'b0);
      chk("mf_cnt7", 256'(bus.lane_cnt), 256'(7));
      bus.clear = 1'b1;
      wr(16'h7777, 1'b1);
      bus.clear = 1'b0;
      chk("mf_cnt",     256'(bus.lane_cnt), 256'(0));
      chk("mf_vec",     bus.vec_out,        '0);
      chk("mf_overrun", 256'(bus.overrun),  256'(1));

      // clear while EMPTY+write in a fresh bench state must not set overrun
      do_reset();
      bus.clear = 1'b1;
      wr(16'h1111, 1'b0);
      bus.clear = 1'b0;
      chk("ce_overrun", 256'(bus.overrun), 256'(0));
      chk("ce_cnt",     256'(bus.lane_cnt), 256'(0));

      // mid-fill reset with overrun set
      for (int i = 0; i < LANES; i++) wr(16'h2222, 1'b0);
      wr(16'h3333, 1'b0);
      bus.vec_ready = 1'b1; tick(); bus.vec_ready = 1'b0;
      for (int i = 0; i < 7; i++) wr(16'h0b00 + 16'(i), 1'b1);
      chk("mr_pre_overrun", 256'(bus.overrun), 256'(1));
      rst = 1'b1;
      wr(16'h6666, 1'b1);
      rst = 1'b0;
      chk("mr_vec",     bus.vec_out,         '0);
      chk("mr_ovf",     256'(bus.vec_ovf),   256'(0));
      chk("mr_cnt",     256'(bus.lane_cnt),  256'(0));
      chk("mr_valid",   256'(bus.vec_valid), 256'(0));
      chk("mr_overrun", 256'(bus.overrun),   256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vdot_result_packer.md
Name: vdot_result_packer

Overview:
Downstream stage of the pipelined 16-lane FP16 dot-product unit. Captures each scalar FP16 dot result on the unit's write pulse and packs 16 successive results into one 256-bit vector, e.g. one row per result for a matrix-vector product. Presents the vector to the vector register file writeback with a valid/ready handshake. Keeps a per-lane overflow mask and a sticky overrun flag for results that arrive while the vector is held.

Parameters:
LANES, 16, number of scalar results packed per output vector
WIDTH, 16, bits per result (FP16 half precision)

Ports:
Clk  input  1  single clock; all state updates on posedge
Rst  input  1  synchronous, active-high reset
clear  input  1  synchronous flush of any partial vector
res_in  input  WIDTH  scalar dot-product result
res_v  input  1  overflow flag accompanying res_in
res_write  input  1  one-cycle pulse; res_in/res_v valid this cycle
vec_out  output  LANES*WIDTH  packed vector; lane i at bits [i*WIDTH +: WIDTH]
vec_ovf  output  LANES  per-lane overflow mask; bit i = res_v of lane i
vec_valid  output  1  packed vector complete and held
vec_ready  input  1  writeback accepts vector when high with vec_valid
lane_cnt  output  $clog2(LANES)+1  number of lanes filled (0..LANES)
overrun  output  1  sticky; a res_write was dropped while FULL

Behaviour:
- Reset (Rst=1 at posedge): vec_out=0, vec_ovf=0, vec_valid=0, lane_cnt=0, overrun=0, state=EMPTY. Rst overrides all other inputs, including mid-fill and while FULL.
- States:
  - EMPTY: lane_cnt=0.
  - FILL: 1 to LANES-1 lanes written.
  - FULL: vec_valid=1.
- res_write in EMPTY/FILL:
  - Writes res_in to lane lane_cnt and res_v to vec_ovf[lane_cnt]; lane_cnt increments.
  - EMPTY moves to FILL. If the write makes lane_cnt==LANES, move to FULL.
- vec_valid rises the cycle after the LANES-th accepted write. This is 1 cycle of latency; all outputs are registered.
- FULL:
  - vec_out and vec_ovf are held stable until the handshake (vec_valid & vec_ready).
  - res_write without a handshake is dropped and sets overrun=1. Stored data is unchanged.
- Handshake in FULL:
  - Next cycle: vec_valid=0, vec_out=0, vec_ovf=0, lane_cnt=0, state=EMPTY.
  - If res_write coincides with the handshake, the result is not dropped. It becomes lane 0 of the new vector: lane_cnt=1, state=FILL, the other lanes are zero.
- vec_ready is ignored when vec_valid=0.
- clear=1 (priority below Rst, above all else):
  - Next cycle matches reset except overrun, which is preserved.
  - A coincident res_write is discarded and does not set overrun.
  - clear in FULL discards the held vector without a handshake.
- overrun clears only on Rst.
- No arithmetic is performed on data: results are stored bit-exact, including NaN/Inf encodings.
- Unwritten lanes read as 0x0000.
- lane_cnt never exceeds LANES and never wraps.

Decomposition:
- Shared package: LANES/WIDTH defaults, FP16 width constant, and the 2-bit state encoding (EMPTY=0, FILL=1, FULL=2), reused by the dot unit and the writeback control.
- No sub-module is natural. Implement as a single module: a lane-indexed write-enable decode plus the FSM.

Test Plan:
- 16 res_write pulses with res_in=16'h3c00, res_v=0, vec_ready=0:
  - vec_valid=1 exactly one cycle after the 16th pulse.
  - vec_out = 16'h3c00 repeated 16 times, vec_ovf=16'h0000, lane_cnt=16.
- Ordering: res_in = 0x0001..0x0010 in sequence, res_v=1 only on the 5th write:
  - vec_out[15:0]=16'h0001, vec_out[255:240]=16'h0010.
  - vec_ovf=16'h0010.
- Backpressure: FULL with vec_ready=0, then one res_write of 16'hbeef:
  - overrun=1; vec_out unchanged; vec_valid stays 1.
  - Later vec_ready=1 for 1 cycle: vec_valid=0, lane_cnt=0.
  - overrun remains 1 until Rst.
- Simultaneous events: FULL, vec_ready=1 and res_write with 16'h4000 in the same cycle:
  - Next cycle: vec_valid=0, lane_cnt=1, vec_out[15:0]=16'h4000, the rest zero, overrun=0.
- Mid-operation flush and reset:
  - After 7 writes, clear=1 coincident with res_write: next cycle lane_cnt=0, vec_out=0, overrun unchanged.
  - Repeat with Rst=1: all outputs zero the next cycle, including overrun.
